// File: rtl/tt_sweep_reader_if.sv
// tt_sweep_reader_if: handshake and circuit-side signals of the truth-table
// sweep reader. The reader uses the slave modport; the host/bench side uses
// the master modport.
interface tt_sweep_reader_if;
    logic       start;
    logic [7:0] expected;
    logic       resp;
    logic [2:0] stim;
    logic       busy;
    logic       done;
    logic [7:0] tt;
    logic       match;
    logic       unstable;

    modport master (
        output start, expected, resp,
        input  stim, busy, done, tt, match, unstable
    );

    modport slave (
        input  start, expected, resp,
        output stim, busy, done, tt, match, unstable
    );
endinterface

// File: rtl/tt_sweep_reader.sv
// tt_sweep_reader: steps a 3-input combinational circuit through all eight
// input rows, holds each row SETTLE_CYCLES cycles, samples the response bit
// and assembles the 8-bit truth-table code (row 000 in the MSB), then
// compares it against the code captured at start.
// Optional feature macro: TT_SWEEP_STABILITY_CHECK_EN -- when defined, the
// response is also registered in the last settle cycle of each row and any
// change by the sample cycle raises a sticky unstable flag that vetoes match.
module tt_sweep_reader #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic            clk,
    input  logic            rst,
    tt_sweep_reader_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       r_state;
    logic [2:0]       r_row;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tt;
    logic [7:0]       r_exp;
    logic             r_match;
    logic [7:0]       w_tt_next;
    logic             w_unst_next;

`ifdef TT_SWEEP_STABILITY_CHECK_EN
    logic             r_resp_settle;
    logic             r_unstable;

    // Response seen at the end of settling, compared again in SAMPLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_settle <= 1'b0;
        end else if (r_state == S_SETTLE && r_cnt == LP_CNT_LAST) begin
            r_resp_settle <= bus.resp;
        end
    end

    // Sticky settle-violation flag, cleared only by a new sweep or reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_unstable <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_unstable <= 1'b0;
        end else if (r_state == S_SAMPLE) begin
            r_unstable <= w_unst_next;
        end
    end

    assign w_unst_next  = r_unstable | (bus.resp != r_resp_settle);
    assign bus.unstable = r_unstable;
`else
    assign w_unst_next  = 1'b0;
    assign bus.unstable = 1'b0;
`endif

    // Truth-table code with the current row's response merged in; row r
    // lands in bit 7-r so that row 000 ends up as the MSB
    always_comb begin
        w_tt_next = r_tt;
        w_tt_next[3'd7 - r_row] = bus.resp;
    end

    // Sweep sequencer: IDLE -> (SETTLE -> SAMPLE) x8 -> DONE -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_row   <= 3'd0;
            r_cnt   <= '0;
            r_tt    <= 8'h00;
            r_exp   <= 8'h00;
            r_match <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_SETTLE;
                        r_row   <= 3'd0;
                        r_cnt   <= '0;
                        r_tt    <= 8'h00;
                        r_match <= 1'b0;
                        r_exp   <= bus.expected;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LP_CNT_LAST) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_tt <= w_tt_next;
                    if (r_row == 3'd7) begin
                        // Final row: the full code is known on this edge, so
                        // the comparison result is ready as DONE begins
                        r_state <= S_DONE;
                        r_match <= (w_tt_next == r_exp) && !w_unst_next;
                    end else begin
                        r_row   <= r_row + 3'd1;
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stimulus is only driven while a row is active; IDLE and DONE show 000
    assign bus.stim  = (r_state == S_SETTLE || r_state == S_SAMPLE) ? r_row : 3'd0;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = (r_state == S_DONE);
    assign bus.tt    = r_tt;
    assign bus.match = r_match;

endmodule

// File: tb/tb_tt_sweep_reader.sv
// Testbench for tt_sweep_reader: a behavioural circuit model (lookup table
// indexed by stim) feeds resp; expected codes and timing come from the
// sweep rules computed with plain arithmetic.
module tb_tt_sweep_reader;

    localparam int S0 = 4;
    localparam int P0 = S0 + 1;
    localparam int L0 = 8 * P0;
    localparam int S1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_sweep_reader_if if0 ();
    tt_sweep_reader_if if1 ();

    tt_sweep_reader #(.SETTLE_CYCLES(S0), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    tt_sweep_reader #(.SETTLE_CYCLES(S1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    bit lut0 [8];
    bit inv0;
    bit resp1;

    assign if0.resp = lut0[if0.stim] ^ inv0;
    assign if1.resp = resp1;

    int checks = 0;
    int errors = 0;

    logic [2:0] tr_stim [0:L0+1];
    logic       tr_busy [0:L0+1];
    logic       tr_done [0:L0+1];
    logic [7:0] tr_tt0, tr_tt_done;
    logic       tr_match_done, tr_unst_done;

    // Circuit out = NOT(in3 AND (in1 XOR in2)), optionally inverted
    function automatic void set_lut_ref(input bit invert);
        for (int r = 0; r < 8; r++) begin
            logic [2:0] s;
            s = 3'(r);
            lut0[r] = !(s[0] & (s[2] ^ s[1])) ^ invert;
        end
    endfunction

    // Expected code: rows read in order 0..7, first row shifted to the MSB
    function automatic logic [7:0] model_tt(input int tog);
        logic [7:0] t;
        t = 8'h00;
        for (int r = 0; r < 8; r++) begin
            t = {t[6:0], lut0[r] ^ (r == tog)};
        end
        return t;
    endfunction

    function automatic bit model_unst(input int tog);
`ifdef TT_SWEEP_STABILITY_CHECK_EN
        return (tog >= 0 && tog < 8);
`else
        return (tog < -100);
`endif
    endfunction

    // One sweep on dut0; tog selects a row whose response flips in SAMPLE
    task automatic do_sweep(input logic [7:0] exp, input int tog);
        if0.expected = exp;
        if0.start    = 1'b1;
        @(posedge clk); #1;
        if0.start    = 1'b0;
        if0.expected = ~exp;
        for (int k = 0; k <= L0 + 1; k++) begin
            inv0 = (tog >= 0) && (k == (tog + 1) * P0 - 1);
            tr_stim[k] = if0.stim;
            tr_busy[k] = if0.busy;
            tr_done[k] = if0.done;
            if (k == 0) tr_tt0 = if0.tt;
            if (k == L0) begin
                tr_tt_done    = if0.tt;
                tr_match_done = if0.match;
                tr_unst_done  = if0.unstable;
            end
            @(posedge clk); #1;
        end
        inv0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if0.start = 1'b0; if0.expected = 8'h00;
        if1.start = 1'b0; if1.expected = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({if0.stim, if0.busy, if0.done, if0.tt, if0.match, if0.unstable} !== 14'd0) begin
            errors++;
            $display("FAIL reset_dut0 got stim=%0d busy=%0b done=%0b tt=%02h match=%0b unst=%0b want all 0",
                     if0.stim, if0.busy, if0.done, if0.tt, if0.match, if0.unstable);
        end
        checks++;
        if ({if1.stim, if1.busy, if1.done, if1.tt, if1.match, if1.unstable} !== 14'd0) begin
            errors++;
            $display("FAIL reset_dut1 got stim=%0d busy=%0b tt=%02h want all 0", if1.stim, if1.busy, if1.tt);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if0.busy !== 1'b0 || if0.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%0b done=%0b want 0 0", if0.busy, if0.done);
        end
    endtask

    task automatic test_reference();
        logic [2:0] es;
        set_lut_ref(1'b0);
        do_sweep(8'hEB, -1);
        for (int k = 0; k <= L0 + 1; k++) begin
            es = (k < L0) ? 3'(k / P0) : 3'd0;
            checks++;
            if (tr_stim[k] !== es) begin
                errors++;
                $display("FAIL ref_stim k=%0d got %0d want %0d", k, tr_stim[k], es);
            end
            checks++;
            if (tr_busy[k] !== (k <= L0)) begin
                errors++;
                $display("FAIL ref_busy k=%0d got %0b want %0b", k, tr_busy[k], (k <= L0));
            end
            checks++;
            if (tr_done[k] !== (k == L0)) begin
                errors++;
                $display("FAIL ref_done k=%0d got %0b want %0b", k, tr_done[k], (k == L0));
            end
        end
        checks++;
        if (tr_tt0 !== 8'h00) begin
            errors++;
            $display("FAIL ref_tt_cleared got %02h want 00", tr_tt0);
        end
        checks++;
        if (tr_tt_done !== 8'hEB || tr_match_done !== 1'b1 || tr_unst_done !== 1'b0) begin
            errors++;
            $display("FAIL ref_result got tt=%02h match=%0b unst=%0b want EB 1 0", tr_tt_done, tr_match_done, tr_unst_done);
        end
        checks++;
        if (if0.tt !== 8'hEB || if0.match !== 1'b1) begin
            errors++;
            $display("FAIL ref_hold got tt=%02h match=%0b want EB 1", if0.tt, if0.match);
        end
    endtask

    task automatic test_mismatch();
        int n;
        set_lut_ref(1'b0);
        do_sweep(8'hEA, -1);
        n = 0;
        for (int k = 0; k <= L0 + 1; k++) n += int'(tr_done[k]);
        checks++;
        if (tr_tt_done !== 8'hEB || tr_match_done !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_result got tt=%02h match=%0b want EB 0", tr_tt_done, tr_match_done);
        end
        checks++;
        if (n != 1 || tr_done[L0] !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_done_pulse got count=%0d want 1", n);
        end
    endtask

    task automatic test_held_start();
        logic [2:0] es;
        logic       eb, ed;
        resp1 = 1'b0;
        if1.expected = 8'h00;
        if1.start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k <= 37; k++) begin
            if (k == 30) if1.start = 1'b0;
            es = (k < 16) ? 3'(k / 2) : ((k >= 18 && k < 34) ? 3'((k - 18) / 2) : 3'd0);
            eb = (k != 17) && (k <= 34);
            ed = (k == 16) || (k == 34);
            checks++;
            if (if1.stim !== es || if1.busy !== eb || if1.done !== ed) begin
                errors++;
                $display("FAIL held_start k=%0d got stim=%0d busy=%0b done=%0b want %0d %0b %0b",
                         k, if1.stim, if1.busy, if1.done, es, eb, ed);
            end
            if (ed) begin
                checks++;
                if (if1.tt !== 8'h00 || if1.match !== 1'b1) begin
                    errors++;
                    $display("FAIL held_result k=%0d got tt=%02h match=%0b want 00 1", k, if1.tt, if1.match);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midsweep();
        set_lut_ref(1'b0);
        if0.expected = 8'hEB;
        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        checks++;
        if (if0.busy !== 1'b1 || if0.stim !== 3'd3 || if0.tt !== (model_tt(-1) & 8'hE0)) begin
            errors++;
            $display("FAIL midsweep_state got busy=%0b stim=%0d tt=%02h want 1 3 %02h",
                     if0.busy, if0.stim, if0.tt, model_tt(-1) & 8'hE0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({if0.stim, if0.busy, if0.done, if0.tt, if0.match, if0.unstable} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset got stim=%0d busy=%0b tt=%02h match=%0b want all 0",
                     if0.stim, if0.busy, if0.tt, if0.match);
        end
        #1 rst = 1'b0;
        do_sweep(8'hEB, -1);
        checks++;
        if (tr_tt_done !== 8'hEB || tr_match_done !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_sweep got tt=%02h match=%0b want EB 1", tr_tt_done, tr_match_done);
        end
    endtask

    task automatic test_stability();
        logic [7:0] mt;
        bit         mu;
        set_lut_ref(1'b0);
        mt = model_tt(5);
        mu = model_unst(5);
        do_sweep(mt, 5);
        checks++;
        if (tr_tt_done !== mt) begin
            errors++;
            $display("FAIL stab_tt got %02h want %02h", tr_tt_done, mt);
        end
        checks++;
        if (tr_unst_done !== mu || tr_match_done !== !mu) begin
            errors++;
            $display("FAIL stab_flags got unst=%0b match=%0b want %0b %0b", tr_unst_done, tr_match_done, mu, !mu);
        end
        checks++;
        if (if0.unstable !== mu) begin
            errors++;
            $display("FAIL stab_sticky got %0b want %0b", if0.unstable, mu);
        end
    endtask

    task automatic test_back_to_back();
        set_lut_ref(1'b0);
        do_sweep(8'hEB, -1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (if0.tt !== 8'hEB) begin
            errors++;
            $display("FAIL b2b_hold got %02h want EB", if0.tt);
        end
        set_lut_ref(1'b1);
        do_sweep(8'h14, -1);
        checks++;
        if (tr_tt0 !== 8'h00) begin
            errors++;
            $display("FAIL b2b_clear got %02h want 00", tr_tt0);
        end
        checks++;
        if (tr_tt_done !== 8'h14 || tr_match_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got tt=%02h match=%0b want 14 1", tr_tt_done, tr_match_done);
        end
    endtask

    task automatic test_random();
        logic [7:0] mt, ex;
        int         tog;
        bit         mu;
        for (int it = 0; it < 8; it++) begin
            for (int r = 0; r < 8; r++) lut0[r] = bit'($urandom_range(0, 1));
            tog = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            mt  = model_tt(tog);
            mu  = model_unst(tog);
            ex  = ($urandom_range(0, 1) == 1) ? mt : 8'($urandom);
            do_sweep(ex, tog);
            checks++;
            if (tr_tt_done !== mt) begin
                errors++;
                $display("FAIL rand_tt it=%0d got %02h want %02h", it, tr_tt_done, mt);
            end
            checks++;
            if (tr_match_done !== (!mu && (mt == ex)) || tr_unst_done !== mu) begin
                errors++;
                $display("FAIL rand_flags it=%0d got match=%0b unst=%0b want %0b %0b",
                         it, tr_match_done, tr_unst_done, (!mu && (mt == ex)), mu);
            end
            checks++;
            if (tr_done[L0] !== 1'b1 || tr_done[L0-1] !== 1'b0 || tr_busy[L0+1] !== 1'b0) begin
                errors++;
                $display("FAIL rand_timing it=%0d got done@%0d=%0b busy@%0d=%0b want 1 0",
                         it, L0, tr_done[L0], L0 + 1, tr_busy[L0+1]);
            end
        end
    endtask

    initial begin
        inv0  = 1'b0;
        resp1 = 1'b0;
        test_reset();
        test_reference();
        test_mismatch();
        test_held_start();
        test_reset_midsweep();
        test_stability();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
